// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helpers for the VGA timing generator.
// Defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_timing_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int DEF_CW       = 10;

   // Full period of one axis (pixels per line or lines per frame).
   function automatic int axis_total(input int active, input int fp,
                                     input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Output bundle of the VGA timing generator.
// LINE_CMP / LINE_IRQ exist only when VGA_TIMING_LINE_IRQ_EN is defined.
interface vga_timing_gen_if #(parameter int CW = 10);
   logic [CW-1:0] x;
   logic [CW-1:0] y;
   logic          hsync;
   logic          vsync;
   logic          de;
   logic          sof;
   logic          eol;
`ifdef VGA_TIMING_LINE_IRQ_EN
   logic [CW-1:0] line_cmp;
   logic          line_irq;

   modport master (output x, y, hsync, vsync, de, sof, eol, line_irq,
                   input  line_cmp);
   modport slave  (input  x, y, hsync, vsync, de, sof, eol, line_irq,
                   output line_cmp);
`else
   modport master (output x, y, hsync, vsync, de, sof, eol);
   modport slave  (input  x, y, hsync, vsync, de, sof, eol);
`endif
endinterface

// File: rtl/timing_axis_counter.sv
// One axis of the raster: enabled counter that wraps at TOTAL-1, resets
// to TOTAL-1 (so the first enabled edge lands on 0), flags terminal count,
// and produces a registered sync decoded from the next count value.
module timing_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int   ACTIVE = DEF_H_ACTIVE,
   parameter int   FP     = DEF_H_FP,
   parameter int   SYNC   = DEF_H_SYNC,
   parameter int   BP     = DEF_H_BP,
   parameter logic POL    = 1'b0,
   parameter int   CW     = DEF_CW
)(
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_en,
   output logic [CW-1:0] o_cnt,
   output logic [CW-1:0] o_cnt_nxt,
   output logic          o_tc,
   output logic          o_sync
);

   localparam int            TOTAL     = axis_total(ACTIVE, FP, SYNC, BP);
   localparam logic [CW-1:0] L_LAST    = CW'(TOTAL - 1);
   localparam logic [CW-1:0] L_SYNC_LO = CW'(ACTIVE + FP);
   localparam logic [CW-1:0] L_SYNC_HI = CW'(ACTIVE + FP + SYNC - 1);

   logic [CW-1:0] r_cnt;
   logic          r_sync;
   logic [CW-1:0] w_nxt;
   logic          w_tc;
   logic          w_in_win;

   assign w_tc     = (r_cnt == L_LAST);
   // Value the counter holds after this edge; equals r_cnt when disabled.
   assign w_nxt    = !i_en ? r_cnt : (w_tc ? '0 : r_cnt + 1'b1);
   assign w_in_win = (w_nxt >= L_SYNC_LO) && (w_nxt <= L_SYNC_HI);

   // Count register and sync decode advance together so sync has no lag.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt  <= L_LAST;
         r_sync <= ~POL;
      end else if (i_en) begin
         r_cnt  <= w_nxt;
         r_sync <= w_in_win ? POL : ~POL;
      end
   end

   assign o_cnt     = r_cnt;
   assign o_cnt_nxt = w_nxt;
   assign o_tc      = w_tc;
   assign o_sync    = r_sync;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: X/Y counters, registered syncs and DE,
// start-of-frame and end-of-line pulses.
// Optional macro VGA_TIMING_LINE_IRQ_EN adds a line-compare interrupt.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE  = DEF_H_ACTIVE,
   parameter int   H_FP      = DEF_H_FP,
   parameter int   H_SYNC    = DEF_H_SYNC,
   parameter int   H_BP      = DEF_H_BP,
   parameter int   V_ACTIVE  = DEF_V_ACTIVE,
   parameter int   V_FP      = DEF_V_FP,
   parameter int   V_SYNC    = DEF_V_SYNC,
   parameter int   V_BP      = DEF_V_BP,
   parameter logic HSYNC_POL = 1'b0,
   parameter logic VSYNC_POL = 1'b0,
   parameter int   CW        = DEF_CW
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   vga_timing_gen_if.master  o_vga
);

   localparam int            H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int            V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam logic [CW-1:0] L_HA    = CW'(H_ACTIVE);
   localparam logic [CW-1:0] L_VA    = CW'(V_ACTIVE);
   localparam logic [CW-1:0] L_HLAST = CW'(H_TOTAL - 1);

   logic [CW-1:0] w_x, w_y, w_x_nxt, w_y_nxt;
   logic          w_h_tc, w_v_tc, w_h_sync, w_v_sync;
   logic          w_v_en;

   logic          r_de;
   logic          r_sof;
   logic          r_eol;

   // Vertical axis steps only on the pixel edge that wraps the line.
   assign w_v_en = i_en & w_h_tc;

   timing_axis_counter #(
      .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP),
      .POL    (HSYNC_POL), .CW (CW)
   ) u_h (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_en      (i_en),
      .o_cnt     (w_x),
      .o_cnt_nxt (w_x_nxt),
      .o_tc      (w_h_tc),
      .o_sync    (w_h_sync)
   );

   timing_axis_counter #(
      .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP),
      .POL    (VSYNC_POL), .CW (CW)
   ) u_v (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_en      (w_v_en),
      .o_cnt     (w_y),
      .o_cnt_nxt (w_y_nxt),
      .o_tc      (w_v_tc),
      .o_sync    (w_v_sync)
   );

   // DE holds with the counters; SOF/EOL are one-cycle pulses from enabled edges.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_de  <= 1'b0;
         r_sof <= 1'b0;
         r_eol <= 1'b0;
      end else begin
         r_sof <= 1'b0;
         r_eol <= 1'b0;
         if (i_en) begin
            r_de  <= (w_x_nxt < L_HA) && (w_y_nxt < L_VA);
            r_sof <= (w_x_nxt == '0) && (w_y_nxt == '0);
            r_eol <= (w_x_nxt == L_HLAST);
         end
      end
   end

`ifdef VGA_TIMING_LINE_IRQ_EN
   logic r_irq;

   // Fires when Y moves onto the compare line; Y never reaches >= V_TOTAL,
   // so out-of-range compare values can never match.
   always_ff @(posedge i_clk) begin
      if (i_rst) r_irq <= 1'b0;
      else       r_irq <= w_v_en && (w_y_nxt == o_vga.line_cmp);
   end

   assign o_vga.line_irq = r_irq;
`endif

   assign o_vga.x     = w_x;
   assign o_vga.y     = w_y;
   assign o_vga.hsync = w_h_sync;
   assign o_vga.vsync = w_v_sync;
   assign o_vga.de    = r_de;
   assign o_vga.sof   = r_sof;
   assign o_vga.eol   = r_eol;

   // Frame terminal count is not needed as an output.
   logic w_unused;
   assign w_unused = w_v_tc;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameters H_FP/H_SYNC/H_BP, 16/96/48, horizontal front porch, sync and back porch widths in pixels.
REQ-003 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-004 Parameters V_FP/V_SYNC/V_BP, 10/2/33, vertical front porch, sync and back porch widths in lines.
REQ-005 Parameters HSYNC_POL/VSYNC_POL, 0/0, asserted sync level (0 = active-low).
REQ-006 Parameter CW, 10, width of the X, Y and LINE_CMP ports; must hold H_TOTAL-1 and V_TOTAL-1.
REQ-007 CLK  in  1  system clock; the only clock; all state changes on its rising edge.
REQ-008 RST  in  1  synchronous, active-high reset.
REQ-009 EN  in  1  pixel enable; counters advance only on CLK edges where EN=1.
REQ-010 X  out  CW  current horizontal position, 0..H_TOTAL-1.
REQ-011 Y  out  CW  current vertical position, 0..V_TOTAL-1.
REQ-012 HSYNC, VSYNC  out  1 each  sync outputs at the configured polarity.
REQ-013 DE  out  1  high when X<H_ACTIVE and Y<V_ACTIVE.
REQ-014 SOF  out  1  start-of-frame pulse; EOL  out  1  end-of-line pulse.
REQ-015 LINE_CMP  in  CW, LINE_IRQ  out  1; both exist only when VGA_TIMING_LINE_IRQ_EN is defined.

Function
REQ-016 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; both are elaboration-time constants.
REQ-017 On an EN cycle, X increments by 1; when X=H_TOTAL-1, X wraps to 0 instead.
REQ-018 Y increments only on EN cycles where X wraps; when such a wrap occurs with Y=V_TOTAL-1, Y wraps to 0.
REQ-019 When EN=0, X, Y, HSYNC, VSYNC and DE all hold their values.
REQ-020 HSYNC is asserted exactly while H_ACTIVE+H_FP <= X <= H_ACTIVE+H_FP+H_SYNC-1; it is deasserted otherwise.
REQ-021 VSYNC is asserted exactly while V_ACTIVE+V_FP <= Y <= V_ACTIVE+V_FP+V_SYNC-1; it is deasserted otherwise.
REQ-022 HSYNC, VSYNC and DE are registered outputs, decoded from the next-count values so they change on the same edge as X and Y; there is zero latency relative to X and Y and no combinational glitches.
REQ-023 SOF is high for exactly one CLK cycle, the cycle after the EN edge that loads (X,Y)=(0,0); it is low otherwise, including while EN=0.
REQ-024 EOL is high for exactly one CLK cycle, the cycle after the EN edge that loads X=H_TOTAL-1.
REQ-025 If RST and EN are high together, RST wins.

Reset
REQ-026 On RST: X=H_TOTAL-1, Y=V_TOTAL-1, DE=0, HSYNC=!HSYNC_POL, VSYNC=!VSYNC_POL, SOF=0, EOL=0, LINE_IRQ=0.
REQ-027 The first EN cycle after reset loads (0,0) and raises SOF; a reset mid-frame takes effect on the next edge and discards the frame in progress.

Configuration
REQ-028 With VGA_TIMING_LINE_IRQ_EN defined, LINE_IRQ pulses for one CLK cycle after the EN edge on which Y changes to a value equal to LINE_CMP; LINE_CMP is sampled on that edge.
REQ-029 With VGA_TIMING_LINE_IRQ_EN defined, a LINE_CMP value >= V_TOTAL never fires LINE_IRQ.
REQ-030 Without VGA_TIMING_LINE_IRQ_EN, neither the LINE_CMP and LINE_IRQ ports nor the compare logic exist; all other behaviour is identical.

Structure
REQ-031 The shared package vga_timing_pkg holds the default 640x480@60 timing constants and a function computing H_TOTAL and V_TOTAL.
REQ-032 The sub-module timing_axis_counter (a counter with enable, wrap at TOTAL-1, terminal-count output, reset to TOTAL-1, and sync-window decode) is instantiated twice, for the horizontal and vertical axes.
REQ-033 The horizontal instance's terminal count AND EN drives the vertical instance's enable.

Verification
REQ-034 Reset, then EN=1 for one cycle -> X=0, Y=0, SOF=1 and DE=1 in the following cycle; SOF=0 one cycle later.
REQ-035 Default parameters with EN=1 constant -> HSYNC is low for X=656..751, 96 cycles per line; EOL recurs every 800 cycles.
REQ-036 Default parameters with EN=1 constant -> VSYNC is low for Y=490..491, 1600 cycles; SOF recurs every 420000 cycles; DE high count per frame = 307200.
REQ-037 EN toggling 1,0,0,1 at X=799,Y=524 -> counters hold during the EN=0 cycles, then wrap to (0,0); SOF fires once.
REQ-038 RST asserted together with EN at X=300,Y=200 -> next cycle X=799, Y=524, DE=0, syncs deasserted.
REQ-039 With the macro defined and LINE_CMP=479 -> LINE_IRQ pulses once per frame as Y becomes 479; with LINE_CMP=600 -> LINE_IRQ never fires.
